// File: rtl/udp_reg_cntr_slave.sv
// UDP register-ring slave: CTRL word plus a bank of event counters, 1-cycle ring pipeline.
// Optional macro UDP_REG_CNTR_CLR_ON_RD_EN makes counter reads destructive (clear-on-read).
module udp_reg_cntr_slave #(
    parameter int unsigned BLOCK_ADDR          = 0,
    parameter int unsigned REG_ADDR_WIDTH      = 4,
    parameter int unsigned NUM_COUNTERS        = 8,
    parameter int unsigned COUNTER_WIDTH       = 32,
    parameter int unsigned UDP_REG_SRC_WIDTH   = 2,
    parameter int unsigned UDP_REG_ADDR_WIDTH  = 23,
    parameter int unsigned CPCI_NF2_DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           reset_L,
    input  logic                           reg_req_in,
    input  logic                           reg_ack_in,
    input  logic                           reg_rd_wr_L_in,
    input  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
    input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in,
    output logic                           reg_req_out,
    output logic                           reg_ack_out,
    output logic                           reg_rd_wr_L_out,
    output logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
    output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out,
    input  logic [NUM_COUNTERS-1:0]        event_in
);

    localparam int unsigned TAG_WIDTH = UDP_REG_ADDR_WIDTH - REG_ADDR_WIDTH;
    localparam logic [TAG_WIDTH-1:0] BLOCK_TAG = TAG_WIDTH'(BLOCK_ADDR);

    logic                      hit;
    logic [REG_ADDR_WIDTH-1:0] word;
    logic                      ctrl_wr;
    logic                      clr_all;
    logic                      cnt_en_reg;
    logic [CPCI_NF2_DATA_WIDTH-1:0] rd_val;
    logic [COUNTER_WIDTH-1:0]  cnt_val [NUM_COUNTERS];

    assign hit     = reg_req_in && !reg_ack_in &&
                     (reg_addr_in[UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH] == BLOCK_TAG);
    assign word    = reg_addr_in[REG_ADDR_WIDTH-1:0];
    assign ctrl_wr = hit && !reg_rd_wr_L_in && (word == '0);
    assign clr_all = ctrl_wr && reg_data_in[1];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_en_reg <= 1'b1;
        end else if (ctrl_wr) begin
            cnt_en_reg <= reg_data_in[0];
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_cnt
            logic [COUNTER_WIDTH-1:0] cnt_reg;
            logic                     sel;
            logic                     wr_sel;
            logic                     inc;

            assign sel     = hit && (word == REG_ADDR_WIDTH'(gi + 1));
            assign wr_sel  = sel && !reg_rd_wr_L_in;
            assign inc     = event_in[gi] && cnt_en_reg;
            assign cnt_val[gi] = cnt_reg;

            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    cnt_reg <= '0;
                end else if (clr_all) begin
                    cnt_reg <= '0;
                end else if (wr_sel) begin
                    cnt_reg <= reg_data_in[COUNTER_WIDTH-1:0];
`ifdef UDP_REG_CNTR_CLR_ON_RD_EN
                end else if (sel && reg_rd_wr_L_in) begin
                    // restart from this cycle's event so no pulse is lost across the read
                    cnt_reg <= COUNTER_WIDTH'(inc);
`else
`endif
                end else if (inc) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        rd_val = '0;
        if (word == '0) begin
            rd_val[0] = cnt_en_reg;
        end
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (word == REG_ADDR_WIDTH'(i + 1)) begin
                rd_val = CPCI_NF2_DATA_WIDTH'(cnt_val[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            reg_req_out     <= 1'b0;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= 1'b0;
            reg_addr_out    <= '0;
            reg_data_out    <= '0;
            reg_src_out     <= '0;
        end else if (hit) begin
            reg_req_out     <= 1'b1;
            reg_ack_out     <= 1'b1;
            reg_rd_wr_L_out <= reg_rd_wr_L_in;
            reg_addr_out    <= reg_addr_in;
            reg_data_out    <= reg_rd_wr_L_in ? rd_val : reg_data_in;
            reg_src_out     <= reg_src_in;
        end else if (reg_req_in) begin
            reg_req_out     <= 1'b1;
            reg_ack_out     <= reg_ack_in;
            reg_rd_wr_L_out <= reg_rd_wr_L_in;
            reg_addr_out    <= reg_addr_in;
            reg_data_out    <= reg_data_in;
            reg_src_out     <= reg_src_in;
        end else begin
            reg_req_out     <= 1'b0;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= 1'b0;
            reg_addr_out    <= '0;
            reg_data_out    <= '0;
            reg_src_out     <= '0;
        end
    end

endmodule
